// File: rtl/mask_centroid.sv
// Per-frame white-pixel area and integer centroid of a binary mask video stream.
// Optional crosshair overlay at the last centroid is enabled by MASK_CENTROID_CROSSHAIR_EN.
module mask_centroid #(
    parameter int X_WIDTH  = 11,
    parameter int Y_WIDTH  = 11,
    parameter int MIN_AREA = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       de_in,
    input  logic                       h_sync_in,
    input  logic                       v_sync_in,
    input  logic [23:0]                pixel_in,
    output logic                       de_out,
    output logic                       h_sync_out,
    output logic                       v_sync_out,
    output logic [23:0]                pixel_out,
    output logic [X_WIDTH-1:0]         x_center,
    output logic [Y_WIDTH-1:0]         y_center,
    output logic [X_WIDTH+Y_WIDTH-1:0] area,
    output logic                       found,
    output logic                       result_valid
);

    localparam int CW  = X_WIDTH + Y_WIDTH;
    localparam int SXW = 2 * X_WIDTH + Y_WIDTH;
    localparam int SYW = X_WIDTH + 2 * Y_WIDTH;
    localparam int QW  = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int SW  = $clog2(QW);

    localparam logic [SW-1:0] LAST_X     = SW'(X_WIDTH - 1);
    localparam logic [SW-1:0] LAST_Y     = SW'(Y_WIDTH - 1);
    localparam logic [CW-1:0] MIN_AREA_C = CW'(MIN_AREA);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV_X,
        DIV_Y,
        DONE
    } state_t;

    state_t state, state_next;

    logic [X_WIDTH-1:0] x_cnt;
    logic [Y_WIDTH-1:0] y_cnt;
    logic [CW-1:0]      cnt, snap_cnt;
    logic [SXW-1:0]     sum_x, snap_sx;
    logic [SYW-1:0]     sum_y, snap_sy;
    logic [CW-1:0]      rem;
    logic [QW-1:0]      dvd;
    logic [SW-1:0]      step;
    logic [X_WIDTH-1:0] x_quot;
    logic [23:0]        pixel_next;

    logic take_snap, load_x, load_y, div_step, finish_nf, finish_found;

    // The delayed video outputs double as the 1-cycle history for edge detection.
    logic de_fall, vs_rise;
    assign de_fall = de_out & ~de_in;
    assign vs_rise = v_sync_in & ~v_sync_out;

    // Video path: plain register stage, independent of the measurement FSM.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            pixel_out  <= '0;
        end else begin
            de_out     <= de_in;
            h_sync_out <= h_sync_in;
            v_sync_out <= v_sync_in;
            pixel_out  <= pixel_next;
        end
    end

`ifdef MASK_CENTROID_CROSSHAIR_EN
    always_comb begin
        pixel_next = pixel_in;
        if (de_in && found && (x_cnt == x_center || y_cnt == y_center))
            pixel_next = 24'hff0000;
    end
`else
    assign pixel_next = pixel_in;
`endif

    // Pixel position: the counter values before this cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (de_in)
                x_cnt <= x_cnt + X_WIDTH'(1);
            else if (de_fall)
                x_cnt <= '0;

            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall)
                y_cnt <= y_cnt + Y_WIDTH'(1);
        end
    end

    // Accumulators always restart on a frame boundary; the snapshot is only
    // taken when the FSM is free to consume it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sum_x    <= '0;
            sum_y    <= '0;
            snap_cnt <= '0;
            snap_sx  <= '0;
            snap_sy  <= '0;
        end else begin
            if (take_snap) begin
                snap_cnt <= cnt;
                snap_sx  <= sum_x;
                snap_sy  <= sum_y;
            end

            if (vs_rise) begin
                cnt   <= '0;
                sum_x <= '0;
                sum_y <= '0;
            end else if (de_in && pixel_in[0]) begin
                cnt   <= cnt + CW'(1);
                sum_x <= sum_x + SXW'(x_cnt);
                sum_y <= sum_y + SYW'(y_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        take_snap    = 1'b0;
        load_x       = 1'b0;
        load_y       = 1'b0;
        div_step     = 1'b0;
        finish_nf    = 1'b0;
        finish_found = 1'b0;
        case (state)
            IDLE: begin
                if (vs_rise) begin
                    take_snap  = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (snap_cnt < MIN_AREA_C) begin
                    finish_nf  = 1'b1;
                    state_next = IDLE;
                end else begin
                    load_x     = 1'b1;
                    state_next = DIV_X;
                end
            end
            DIV_X: begin
                div_step = 1'b1;
                if (step == LAST_X) begin
                    load_y     = 1'b1;
                    state_next = DIV_Y;
                end
            end
            DIV_Y: begin
                div_step = 1'b1;
                if (step == LAST_Y) begin
                    finish_found = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Restoring divider step. The partial remainder starts as the dividend's
    // upper bits (always < divisor, since the quotient fits its counter width);
    // low dividend bits shift out of dvd MSB-first while quotient bits shift in.
    logic [CW:0]   trial;
    logic          q_bit;
    logic [CW-1:0] rem_next;
    logic [QW-1:0] dvd_next;

    always_comb begin
        trial    = {rem, dvd[QW-1]};
        q_bit    = (trial >= {1'b0, snap_cnt});
        rem_next = q_bit ? (trial[CW-1:0] - snap_cnt) : trial[CW-1:0];
        dvd_next = {dvd[QW-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            dvd    <= '0;
            step   <= '0;
            x_quot <= '0;
        end else begin
            if (load_x) begin
                rem  <= snap_sx[SXW-1:X_WIDTH];
                dvd  <= QW'(snap_sx[X_WIDTH-1:0]) << (QW - X_WIDTH);
                step <= '0;
            end

            if (div_step) begin
                rem  <= rem_next;
                dvd  <= dvd_next;
                step <= step + SW'(1);
            end

            // Last x step: keep the x quotient, then reuse the datapath for y.
            if (load_y) begin
                x_quot <= dvd_next[X_WIDTH-1:0];
                rem    <= snap_sy[SYW-1:Y_WIDTH];
                dvd    <= QW'(snap_sy[Y_WIDTH-1:0]) << (QW - Y_WIDTH);
                step   <= '0;
            end
        end
    end

    // Published results; the update lands in the DONE cycle for found frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_center     <= '0;
            y_center     <= '0;
            area         <= '0;
            found        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (finish_nf) begin
                area         <= snap_cnt;
                found        <= 1'b0;
                result_valid <= 1'b1;
            end
            if (finish_found) begin
                x_center     <= x_quot;
                y_center     <= dvd_next[Y_WIDTH-1:0];
                area         <= snap_cnt;
                found        <= 1'b1;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mask_centroid.sv
// Self-checking bench for mask_centroid: directed and random frames against a
// mask-array reference model; crosshair expectations follow MASK_CENTROID_CROSSHAIR_EN.
module tb_mask_centroid;

    localparam int XW = 11;
    localparam int YW = 11;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           de_in, h_sync_in, v_sync_in;
    logic [23:0]    pixel_in;
    logic           de_out, h_sync_out, v_sync_out;
    logic [23:0]    pixel_out;
    logic [XW-1:0]  x_center;
    logic [YW-1:0]  y_center;
    logic [XW+YW-1:0] area;
    logic           found, result_valid;

    always #5 clk = ~clk;

    mask_centroid #(.X_WIDTH(XW), .Y_WIDTH(YW), .MIN_AREA(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .pixel_in(pixel_in),
        .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out),
        .x_center(x_center), .y_center(y_center), .area(area), .found(found),
        .result_valid(result_valid)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    bit mask [0:7][0:15];
    int fw, fh;

    // Model of the currently published result (drives crosshair expectations).
    int m_found = 0;
    int m_xc    = 0;
    int m_yc    = 0;

    // One clock of video: drive inputs, then check the registered copy.
    task automatic cycle(input logic de, input logic vs, input logic [23:0] pix,
                         input int px, input int py);
        logic        hs;
        logic [23:0] exp_pix;
        hs        = 1'($urandom);
        de_in     = de;
        v_sync_in = vs;
        h_sync_in = hs;
        pixel_in  = pix;
        exp_pix   = pix;
`ifdef MASK_CENTROID_CROSSHAIR_EN
        if (de && m_found == 1 && (px == m_xc || py == m_yc))
            exp_pix = 24'hff0000;
`endif
        @(posedge clk);
        #1;
        total_cnt++;
        if ({de_out, h_sync_out, v_sync_out, pixel_out} !== {de, hs, vs, exp_pix}) begin
            bad_cnt++;
            $display("FAIL video at (%0d,%0d): got de=%b hs=%b vs=%b pix=%h, want de=%b hs=%b vs=%b pix=%h",
                     px, py, de_out, h_sync_out, v_sync_out, pixel_out, de, hs, vs, exp_pix);
        end
    endtask

    task automatic clear_mask(input int w, input int h);
        fw = w;
        fh = h;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++)
                mask[y][x] = 1'b0;
    endtask

    task automatic send_frame();
        logic [23:0] pix;
        for (int y = 0; y < fh; y++) begin
            for (int x = 0; x < fw; x++) begin
                pix    = 24'($urandom);
                pix[0] = mask[y][x];
                cycle(1'b1, 1'b0, pix, x, y);
            end
            for (int b = 0; b < 3; b++)
                cycle(1'b0, 1'b0, 24'($urandom), -1, -1);
        end
    endtask

    // Raise v_sync, watch the result for 40 cycles and compare with the model.
    // With gap set, white pixels arrive before a second (dropped) boundary.
    task automatic end_frame(input string name, input bit gap);
        int a, sx, sy, ex, ey, ef, elat, lat, pulses;
        logic [XW-1:0]    cx;
        logic [YW-1:0]    cy;
        logic [XW+YW-1:0] ca;
        logic             cf;
        logic             de, vs;
        logic [23:0]      pix;
        a = 0; sx = 0; sy = 0;
        for (int y = 0; y < fh; y++)
            for (int x = 0; x < fw; x++)
                if (mask[y][x]) begin
                    a++;
                    sx += x;
                    sy += y;
                end
        ef   = (a >= 1) ? 1 : 0;
        ex   = ef ? sx / a : m_xc;
        ey   = ef ? sy / a : m_yc;
        elat = ef ? 24 : 2;
        lat = -1; pulses = 0;
        cx = '0; cy = '0; ca = '0; cf = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            de  = gap && n >= 3 && n <= 5;
            vs  = (n <= 2) || (gap && (n == 6 || n == 7));
            pix = 24'($urandom);
            if (de) pix[0] = 1'b1;
            cycle(de, vs, pix, n - 3, 0);
            if (result_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    cx = x_center; cy = y_center; ca = area; cf = found;
                    m_found = ef; m_xc = ex; m_yc = ey;
                end
            end
        end
        total_cnt++;
        if (lat !== elat) begin
            bad_cnt++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
        end
        total_cnt++;
        if (pulses !== 1) begin
            bad_cnt++;
            $display("FAIL %s pulse count: got %0d want 1", name, pulses);
        end
        total_cnt++;
        if ({cx, cy, ca, cf} !== {XW'(ex), YW'(ey), (XW+YW)'(a), 1'(ef)}) begin
            bad_cnt++;
            $display("FAIL %s result: got x=%0d y=%0d area=%0d found=%0d want x=%0d y=%0d area=%0d found=%0d",
                     name, cx, cy, ca, cf, ex, ey, a, ef);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            de_in = 1'($urandom); h_sync_in = 1'($urandom);
            v_sync_in = 1'($urandom); pixel_in = 24'($urandom);
            @(posedge clk);
        end
        #1;
        total_cnt++;
        if ({de_out, h_sync_out, v_sync_out, pixel_out, x_center, y_center, area, found, result_valid} !== '0) begin
            bad_cnt++;
            $display("FAIL reset outputs: got de=%b pix=%h x=%0d y=%0d area=%0d found=%b rv=%b want all 0",
                     de_out, pixel_out, x_center, y_center, area, found, result_valid);
        end
        de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = '0;
        rst_n = 1'b1;
        m_found = 0; m_xc = 0; m_yc = 0;
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 24'($urandom), -1, -1);
    endtask

    task automatic test_single_pixel();
        clear_mask(16, 8);
        mask[3][5] = 1'b1;
        send_frame();
        end_frame("single_pixel", 1'b0);
    endtask

    task automatic test_block();
        clear_mask(16, 8);
        for (int y = 2; y <= 4; y++)
            for (int x = 4; x <= 6; x++)
                mask[y][x] = 1'b1;
        send_frame();
        end_frame("block3x3", 1'b0);
    endtask

    task automatic test_floor();
        clear_mask(16, 8);
        mask[0][2] = 1'b1;
        mask[0][3] = 1'b1;
        send_frame();
        end_frame("floor_pair", 1'b0);
    endtask

    task automatic test_black();
        clear_mask(16, 8);
        send_frame();
        end_frame("all_black", 1'b0);
    endtask

    task automatic test_back_to_back();
        clear_mask(16, 8);
        mask[6][9] = 1'b1;
        send_frame();
        end_frame("b2b_first", 1'b1);
        clear_mask(16, 8);
        mask[1][1] = 1'b1;
        mask[1][3] = 1'b1;
        send_frame();
        end_frame("b2b_next", 1'b0);
    endtask

    task automatic test_random();
        int dens;
        for (int f = 0; f < 6; f++) begin
            clear_mask($urandom_range(16, 4), $urandom_range(8, 2));
            dens = (f == 0) ? 0 : $urandom_range(90, 5);
            for (int y = 0; y < fh; y++)
                for (int x = 0; x < fw; x++)
                    mask[y][x] = ($urandom_range(99, 0) < dens);
            send_frame();
            end_frame($sformatf("random%0d", f), 1'b0);
        end
    endtask

    task automatic test_reset_mid_div();
        int pulses;
        clear_mask(16, 8);
        mask[7][15] = 1'b1;
        mask[0][0]  = 1'b1;
        send_frame();
        pulses = 0;
        for (int n = 1; n <= 16; n++) begin
            cycle(1'b0, n <= 2, 24'($urandom), -1, -1);
            if (result_valid === 1'b1) pulses++;
        end
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({de_out, h_sync_out, v_sync_out, pixel_out, x_center, y_center, area, found, result_valid} !== '0) begin
            bad_cnt++;
            $display("FAIL mid_div reset outputs: got de=%b pix=%h x=%0d y=%0d area=%0d found=%b rv=%b want all 0",
                     de_out, pixel_out, x_center, y_center, area, found, result_valid);
        end
        m_found = 0; m_xc = 0; m_yc = 0;
        for (int i = 0; i < 3; i++) begin
            de_in = 1'($urandom); pixel_in = 24'($urandom);
            @(posedge clk);
        end
        #1;
        de_in = 1'b0;
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            cycle(1'b0, 1'b0, 24'($urandom), -1, -1);
            if (result_valid === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) begin
            bad_cnt++;
            $display("FAIL mid_div abandoned result: got %0d pulses want 0", pulses);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = '0;
        test_reset();
        test_single_pixel();
        test_block();
        test_floor();
        test_black();
        test_back_to_back();
        test_random();
        test_reset_mid_div();
        test_single_pixel();
        test_block();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
